// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
//
// Purpose:
//   Elastic inter-stage pipeline register. It chains DEPTH register slices,
//   each holding a DATA_W-bit payload and its own valid bit. The block uses a
//   valid/ready handshake, so downstream back-pressure holds data in place
//   instead of dropping it. A ready chain that ripples from the output side
//   lets bubbles collapse while the output is stalled. It also lets a full
//   chain accept and emit an entry in the same cycle.
//   hlt freezes every register and blocks both handshakes. flush squashes
//   every in-flight entry and clears the payload registers.
//
// Parameters:
//   DATA_W  payload width in bits (>= 1)
//   DEPTH   number of register slices, equal to the latency in cycles (>= 1)
//   CNT_W   occupancy counter width, derived from DEPTH (not overridable)
//
// Ports:
//   clk        in   1       system clock; all state updates on the rising edge
//   rst_n      in   1       asynchronous active-low reset
//   hlt        in   1       freeze: no state changes, handshakes blocked
//   flush      in   1       squash all in-flight entries on the next edge
//   in_valid   in   1       upstream presents in_data
//   in_ready   out  1       block accepts in_data this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data is valid toward downstream
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  DATA_W  payload of the last slice (driven even when invalid)
//   occupancy  out  CNT_W   number of valid slices, 0..DEPTH
//   stall_cnt  out  32      only when PIPE_STALL_CNT_EN is defined
//
// Configuration macro:
//   PIPE_STALL_CNT_EN
//     When defined, the stall_cnt port and a saturating 32-bit counter are
//     added. The counter counts the edges on which the last slice holds a
//     valid entry, downstream is not ready, and the block is not halted.
//     Only reset clears the counter; flush leaves it unchanged.
//     When undefined, both the port and the counter are absent.
// -----------------------------------------------------------------------------
module elastic_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`else
`endif
);

  // Population count of the slice valid bits.
  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
    return cnt;
  endfunction

  // Slice state. Index 0 is the input side; index DEPTH-1 drives the output.
  logic [DEPTH-1:0]             v;
  logic [DEPTH-1:0][DATA_W-1:0] d;

  // rdy[i]: slice i may load from its predecessor (or from in_data) this cycle.
  logic [DEPTH-1:0]             rdy;

  // Ready chain, rippled from the output side toward the input.
  // A slice can load when it is empty or when its successor can load.
  // A scalar accumulator carries the ripple so that rdy depends only on
  // v and out_ready, and never on itself.
  always_comb begin
    logic acc;
    rdy = {DEPTH{1'b0}};
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = ~v[i] | acc;
      rdy[i] = acc;
    end
  end

  // Handshake-side outputs; hlt and flush both close the input port.
  always_comb begin
    in_ready  = rdy[0] & ~hlt & ~flush;
    out_valid = v[DEPTH-1] & ~hlt;
    out_data  = d[DEPTH-1];
    occupancy = popcount(v);
  end

  // Slice registers, with priority reset > flush > hlt > normal advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= {DEPTH{1'b0}};
      d <= {(DEPTH * DATA_W){1'b0}};
    end else if (flush) begin
      v <= {DEPTH{1'b0}};
      d <= {(DEPTH * DATA_W){1'b0}};
    end else if (hlt) begin
      v <= v;
      d <= d;
    end else begin
      // The input slice takes the upstream valid whenever it can load.
      // Its payload changes only when a valid entry actually arrives.
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= in_data;
        end else begin
          d[0] <= d[0];
        end
      end else begin
        v[0] <= v[0];
        d[0] <= d[0];
      end
      // Downstream slices take their predecessor. An invalid entry moving
      // forward leaves the old payload in place, so d[i] only ever holds
      // data that was once valid, or zero.
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end else begin
            d[i] <= d[i];
          end
        end else begin
          v[i] <= v[i];
          d[i] <= d[i];
        end
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of output-stall edges. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (v[DEPTH-1] && !out_ready && !hlt && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`else
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
//
// Directed self-checking bench for elastic_pipe_reg with DEPTH=3 and DATA_W=32.
// It covers the following behaviour:
//   - reset state
//   - streaming at full throughput
//   - back-pressure with a same-cycle accept while full
//   - flush with a dropped input
//   - hlt freeze followed by an in-order resume
//   - asynchronous reset applied mid-cycle
//   - the stall counter, when PIPE_STALL_CNT_EN is defined
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              hlt;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  elastic_pipe_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hlt       (hlt),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    if (obs !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expected);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the input port, then let combinational outputs settle
  task automatic drive(input logic vld, input logic [31:0] data, input logic ordy);
    in_valid  = vld;
    in_data   = data;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hlt = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;

    // Reset state
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  out_data,       32'd0);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
`ifdef PIPE_STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    tick();

    // Test 1: stream 1..4 with out_ready=1; entry n appears at iteration n+2
    for (int k = 0; k < 8; k++) begin
      drive(k < 4, 32'(k + 1), 1'b1);
      check_eq("t1_in_ready", 32'(in_ready), 32'd1);
      if (k >= 3 && k <= 6) begin
        check_eq("t1_out_valid", 32'(out_valid), 32'd1);
        check_eq("t1_out_data",  out_data,       32'(k - 2));
      end else begin
        check_eq("t1_out_idle", 32'(out_valid), 32'd0);
      end
      tick();
    end

    // Test 2: fill against back-pressure, then a same-cycle in/out transfer
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(10 + k), 1'b0);
      tick();
    end
    drive(1'b1, 32'd99, 1'b0);
    check_eq("t2_full_occ",   32'(occupancy), 32'd3);
    check_eq("t2_full_rdy",   32'(in_ready),  32'd0);
    check_eq("t2_full_vld",   32'(out_valid), 32'd1);
    check_eq("t2_full_data",  out_data,       32'd10);
    tick();
    check_eq("t2_hold_data",  out_data,       32'd10);
    check_eq("t2_hold_occ",   32'(occupancy), 32'd3);
    drive(1'b1, 32'd9, 1'b1);
    check_eq("t2_pass_rdy",   32'(in_ready),  32'd1);
    tick();
    check_eq("t2_pass_occ",   32'(occupancy), 32'd3);
    check_eq("t2_pass_data",  out_data,       32'd11);
    drive(1'b0, 32'd0, 1'b1);
    tick();
    check_eq("t2_drain_12",   out_data,       32'd12);
    tick();
    check_eq("t2_drain_9",    out_data,       32'd9);
    tick();
    check_eq("t2_drain_end",  32'(out_valid), 32'd0);
    check_eq("t2_drain_occ",  32'(occupancy), 32'd0);

    // Test 3: occupancy 2, flush together with an offered input
    drive(1'b1, 32'd20, 1'b0); tick();
    drive(1'b1, 32'd21, 1'b0); tick();
    drive(1'b0, 32'd0,  1'b0); tick();
    check_eq("t3_pre_occ",    32'(occupancy), 32'd2);
    check_eq("t3_pre_data",   out_data,       32'd20);
    flush = 1'b1;
    drive(1'b1, 32'd55, 1'b0);
    check_eq("t3_flush_rdy",  32'(in_ready),  32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    check_eq("t3_post_occ",   32'(occupancy), 32'd0);
    check_eq("t3_post_vld",   32'(out_valid), 32'd0);
    check_eq("t3_post_data",  out_data,       32'd0);
    tick();
    check_eq("t3_dropped",    32'(occupancy), 32'd0);

    // Test 4: hlt with two entries in flight, then an in-order resume
    drive(1'b1, 32'd30, 1'b1); tick();
    drive(1'b1, 32'd31, 1'b1); tick();
    hlt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'd33, 1'b1);
      check_eq("t4_hlt_rdy", 32'(in_ready),  32'd0);
      check_eq("t4_hlt_vld", 32'(out_valid), 32'd0);
      check_eq("t4_hlt_occ", 32'(occupancy), 32'd2);
      tick();
    end
    hlt = 1'b0;
    drive(1'b1, 32'd32, 1'b1);
    check_eq("t4_rel_occ", 32'(occupancy), 32'd2);
    tick();
    drive(1'b1, 32'd33, 1'b1);
    check_eq("t4_res_30", out_data, 32'd30);
    check_eq("t4_res_v",  32'(out_valid), 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    check_eq("t4_res_31", out_data, 32'd31);
    tick();
    check_eq("t4_res_32", out_data, 32'd32);
    tick();
    check_eq("t4_res_33", out_data, 32'd33);
    tick();
    check_eq("t4_res_end", 32'(out_valid), 32'd0);

    // Test 5: asynchronous reset pulse between edges while full
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(40 + k), 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    check_eq("t5_pre_occ", 32'(occupancy), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_occ",  32'(occupancy), 32'd0);
    check_eq("t5_rst_vld",  32'(out_valid), 32'd0);
    check_eq("t5_rst_data", out_data,       32'd0);
    check_eq("t5_rst_rdy",  32'(in_ready),  32'd1);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("t5_after_occ", 32'(occupancy), 32'd0);

`ifdef PIPE_STALL_CNT_EN
    // Test 6: five stall edges, then a flush that must not clear the count
    drive(1'b1, 32'd50, 1'b1); tick();
    drive(1'b0, 32'd0,  1'b1); tick();
    drive(1'b0, 32'd0,  1'b1); tick();
    check_eq("t6_vld", 32'(out_valid), 32'd1);
    check_eq("t6_cnt0", stall_cnt, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'd0, 1'b0);
      tick();
    end
    check_eq("t6_cnt5", stall_cnt, 32'd5);
    flush = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    tick();
    flush = 1'b0;
    check_eq("t6_flush_cnt", stall_cnt, 32'd5);
    check_eq("t6_flush_occ", 32'(occupancy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
